// File: rtl/imem_responder_if.sv
// Fetch request/response channel between a program counter and the
// instruction-memory responder. Both halves are plain valid/ready.
interface imem_responder_if #(
   parameter int n = 32
);
   logic         req_valid;
   logic         req_ready;
   logic [n-1:0] req_addr;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [n-1:0] rsp_instr;
   logic [n-1:0] rsp_addr;
   logic [1:0]   rsp_err;

   // Requester side (pc / fetch unit)
   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );

   // Responder side (instruction memory)
   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory read responder.
// Accepts one fetch address at a time, reads a word-addressed ROM and
// returns the word LAT cycles later. Misaligned and out-of-range fetches
// come back with rsp_err set and a zero instruction.
// The ROM image is supplied as the ROM_INIT parameter array so the contents
// are fixed at elaboration and no file access is needed.
module imem_responder #(
   parameter int           n        = 32,
   parameter int           DEPTH    = 256,
   parameter int           LAT      = 2,
   parameter logic [n-1:0] ROM_INIT [DEPTH] = '{default: '0}
) (
   input  logic            clk,
   input  logic            rst,     // active-low, asynchronous
   imem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;       // LAT-1 fits in two bits for LAT <= 4
   logic [n-1:0] addr_q, instr_q;
   logic [1:0]   err_q, err_d;
   logic         accept;
   logic [AW-1:0] rom_idx;

   // Can take a new request when idle, or when the held response drains this edge
   assign bus.req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
   assign accept        = bus.req_valid & bus.req_ready;

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_instr = instr_q;
   assign bus.rsp_addr  = addr_q;
   assign bus.rsp_err   = err_q;

   // Error classification of the incoming address; any word index at or
   // beyond DEPTH is out of range, so high addresses never alias into the ROM
   always_comb begin
      err_d[0] = |bus.req_addr[1:0];
      err_d[1] = (bus.req_addr >> 2) >= n'(DEPTH);
      rom_idx  = bus.req_addr[AW+1:2];
   end

   // Next-state logic: load the latency counter on accept, count down in BUSY
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = 2'(LAT - 1);
               state_d = (LAT == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = RESP;
         end
         RESP: begin
            if (accept) begin
               cnt_d   = 2'(LAT - 1);
               state_d = (LAT == 1) ? RESP : BUSY;
            end else if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latency counter registers; reset drops any fetch in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response payload is captured once per accept and held until the next one,
   // which keeps it stable under backpressure; errored fetches skip the ROM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         err_q   <= '0;
         instr_q <= '0;
      end else if (accept) begin
         addr_q  <= bus.req_addr;
         err_q   <= err_d;
         instr_q <= (|err_d) ? '0 : ROM_INIT[rom_idx];
      end
   end

endmodule
